// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback. It drives the datapath enables and mux
// selects, and waits on the shared memory port's ready handshake.
//
// state        | meaning
// -------------+-------------------------------------------------------
// st_fetch     | read instruction at PC, PC <= PC+4 and IR load on ready
// st_decode    | ALUOut <= OldPC+imm (branch/JAL target), pick class
// st_memadr    | ALUOut <= A+imm (load/store effective address)
// st_memread   | load access at ALUOut, wait for ready
// st_memwb     | write loaded Data to rd
// st_memwrite  | store access at ALUOut, retire on ready
// st_execr     | ALUOut <= A op rs2
// st_execi     | ALUOut <= A op imm
// st_lui       | ALUOut <= 0 + imm
// st_aluwb     | write ALUOut to rd
// st_jal       | PC <= ALUOut (target), ALUOut <= OldPC+4
// st_jalr      | PC <= A+imm straight from the ALU
// st_jlink     | rd <= OldPC+4 straight from the ALU
// st_branch    | compare rs1/rs2, PC <= ALUOut when taken
// st_trap      | unsupported instruction, parked until reset

// ALU operation select from ALUOp and the instruction function fields.
module alu_decoder (
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [3:0] alu_control
);
    // 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt,
    // 0110 sltu, 0111 sll, 1000 srl, 1001 sra
    always_comb begin
        alu_control = 4'b0000;
        case (alu_op)
            2'b00: alu_control = 4'b0000;
            2'b01: alu_control = 4'b0001;
            default: begin
                case (funct3)
                    // addi never subtracts; only R-type add/sub looks at bit 30
                    3'b000: alu_control = (op5 && funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001: alu_control = 4'b0111;
                    3'b010: alu_control = 4'b0101;
                    3'b011: alu_control = 4'b0110;
                    3'b100: alu_control = 4'b0100;
                    // bit 30 picks sra/srai for both R and I forms
                    3'b101: alu_control = funct7b5 ? 4'b1001 : 4'b1000;
                    3'b110: alu_control = 4'b0011;
                    default: alu_control = 4'b0010;
                endcase
            end
        endcase
    end
endmodule

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       ALUR31,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       instret,
    output logic       illegal
);
    typedef enum logic [3:0] {
        st_fetch, st_decode, st_memadr, st_memread, st_memwb, st_memwrite,
        st_execr, st_execi, st_lui, st_aluwb, st_jal, st_jalr, st_jlink,
        st_branch, st_trap
    } state_t;

    state_t     state, state_nx;
    logic [1:0] alu_op;
    logic       take;
    logic       br_legal;

    alu_decoder u_alu_dec (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_op     (alu_op),
        .alu_control(ALUControl)
    );

    // State register; reset abandons any in-flight access and restarts fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= st_fetch;
        else        state <= state_nx;
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: ImmSrc = 3'b000;
            7'b0100011: ImmSrc = 3'b001;
            7'b1100011: ImmSrc = 3'b010;
            7'b1101111: ImmSrc = 3'b011;
            7'b0110111: ImmSrc = 3'b100;
            default:    ImmSrc = 3'b000;
        endcase
    end

    // Branch condition from the ALU flags; funct3 010/011 are not branches.
    always_comb begin
        br_legal = (funct3[2:1] != 2'b01);
        case (funct3)
            3'b000:         take = Zero;
            3'b001:         take = !Zero;
            3'b100, 3'b110: take = ALUR31;
            3'b101, 3'b111: take = !ALUR31;
            default:        take = 1'b0;
        endcase
    end

    // Per-state control decode and next-state selection.
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_op    = 2'b00;
        instret   = 1'b0;
        illegal   = 1'b0;
        case (state)
            st_fetch: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    state_nx = st_decode;
                end
            end
            st_decode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_nx = st_memadr;
                    7'b0110011: state_nx = st_execr;
                    7'b0010011: state_nx = st_execi;
                    7'b1100011: state_nx = st_branch;
                    7'b1101111: state_nx = st_jal;
                    7'b1100111: state_nx = st_jalr;
                    7'b0110111: state_nx = st_lui;
                    default:    state_nx = st_trap;
                endcase
            end
            st_memadr: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                state_nx = op[5] ? st_memwrite : st_memread;
            end
            st_memread: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_nx = st_memwb;
            end
            st_memwb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                instret   = 1'b1;
                state_nx  = st_fetch;
            end
            st_memwrite: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instret  = 1'b1;
                    state_nx = st_fetch;
                end
            end
            st_execr: begin
                ALUSrcA  = 2'b10;
                alu_op   = 2'b10;
                state_nx = st_aluwb;
            end
            st_execi: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                alu_op   = 2'b10;
                state_nx = st_aluwb;
            end
            st_lui: begin
                ALUSrcA  = 2'b11;
                ALUSrcB  = 2'b01;
                state_nx = st_aluwb;
            end
            st_aluwb: begin
                RegWrite = 1'b1;
                instret  = 1'b1;
                state_nx = st_fetch;
            end
            st_jal: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCWrite  = 1'b1;
                state_nx = st_aluwb;
            end
            st_jalr: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_nx  = st_jlink;
            end
            st_jlink: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
                instret   = 1'b1;
                state_nx  = st_fetch;
            end
            st_branch: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                if (br_legal) begin
                    PCWrite  = take;
                    instret  = 1'b1;
                    state_nx = st_fetch;
                end else begin
                    state_nx = st_trap;
                end
            end
            st_trap: illegal = 1'b1;
            default: state_nx = st_fetch;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each fetched instruction is expanded into
// a script of expected per-step controls; every cycle the DUT is compared to
// the script head. Directed runs pin cycle counts with literal values.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, ALUR31, mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       instret, illegal;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .ALUR31(ALUR31), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instret(instret),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011,
        OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BR = 7'b1100011,
        OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    typedef struct packed {
        logic [1:0] a, b, rs, aluop;
        logic mreq, adr, mwr, rw, ret, pcw, br, trap_next;
    } step_t;

    step_t script[$];
    bit    trapped;
    bit    rand_ready;
    int    fw_left, mw_left;
    int    errors = 0, checks = 0;
    bit    last_rw, last_ret, last_pcw, last_fetch, last_strobe, last_ill;
    int    n_rw, n_ret, n_pcw_x, ret_cyc;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic step_t st(logic [1:0] a, logic [1:0] b, logic [1:0] rs,
                                 logic [1:0] aluop, logic rw, logic ret, logic pcw);
        step_t s = '0;
        s.a = a; s.b = b; s.rs = rs; s.aluop = aluop;
        s.rw = rw; s.ret = ret; s.pcw = pcw;
        return s;
    endfunction

    function automatic step_t mem_step(logic wr);
        step_t s = '0;
        s.mreq = 1'b1; s.adr = 1'b1; s.mwr = wr; s.ret = wr;
        return s;
    endfunction

    // Expand a freshly fetched instruction into its remaining steps.
    function automatic void plan(logic [6:0] o);
        step_t d = st(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step_t b;
        script.delete();
        d.trap_next = !(o inside {OP_LD, OP_ST, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI});
        script.push_back(d);
        case (o)
            OP_LD: begin
                script.push_back(st(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
                script.push_back(mem_step(1'b0));
                script.push_back(st(2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0));
            end
            OP_ST: begin
                script.push_back(st(2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
                script.push_back(mem_step(1'b1));
            end
            OP_R, OP_I, OP_LUI: begin
                if (o == OP_R)      script.push_back(st(2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0));
                else if (o == OP_I) script.push_back(st(2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0));
                else                script.push_back(st(2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
                script.push_back(st(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0));
            end
            OP_JAL: begin
                script.push_back(st(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
                script.push_back(st(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0));
            end
            OP_JALR: begin
                script.push_back(st(2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1));
                script.push_back(st(2'b01, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0));
            end
            OP_BR: begin
                b = st(2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
                b.br = 1'b1;
                script.push_back(b);
            end
            default: ;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(logic [6:0] o);
        if (o == OP_LD || o == OP_I || o == OP_JALR) return 3'd0;
        if (o == OP_ST)  return 3'd1;
        if (o == OP_BR)  return 3'd2;
        if (o == OP_JAL) return 3'd3;
        if (o == OP_LUI) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] exp_ctl(logic [1:0] aop, logic [6:0] o,
                                          logic [2:0] f3, logic f7);
        // indexed by funct3: add sll slt sltu xor srl or and
        logic [3:0] tbl [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (aop == 2'b00) return 4'd0;
        if (aop == 2'b01) return 4'd1;
        if (f3 == 3'd0 && o[5] && f7) return 4'd1;
        if (f3 == 3'd5 && f7) return 4'd9;
        return tbl[f3];
    endfunction

    // One clock: choose mem_ready, compare at mid-cycle, advance the model.
    task automatic cycle();
        step_t s = '0;
        bit fetch, ready, legal, take, ret, pcw;
        logic [20:0] e, a;
        logic [1:0] aop;
        fetch = !trapped && script.size() == 0;
        if (!trapped && !fetch) s = script[0];
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
        else if (fetch) begin mem_ready = (fw_left == 0); if (fw_left > 0) fw_left--; end
        else if (s.mreq) begin mem_ready = (mw_left == 0); if (mw_left > 0) mw_left--; end
        else mem_ready = 1'($urandom_range(0, 1));
        #3;
        legal = !(funct3 == 3'd2 || funct3 == 3'd3);
        case (funct3)
            3'd0: take = Zero;
            3'd1: take = !Zero;
            3'd4, 3'd6: take = ALUR31;
            3'd5, 3'd7: take = !ALUR31;
            default: take = 1'b0;
        endcase
        ready = !s.mreq || mem_ready;
        if (trapped) begin
            e = {6'b0, 6'b0, exp_imm(op), exp_ctl(2'b00, op, funct3, funct7b5), 1'b0, 1'b1};
        end else if (fetch) begin
            e = {1'b1, 1'b0, 1'b0, mem_ready, mem_ready, 1'b0, 2'b00, 2'b10, 2'b10,
                 exp_imm(op), exp_ctl(2'b00, op, funct3, funct7b5), 1'b0, 1'b0};
        end else begin
            aop = s.aluop;
            ret = s.br ? legal : (s.ret && ready);
            pcw = s.br ? (legal && take) : s.pcw;
            e = {s.mreq, s.mwr, s.adr, 1'b0, pcw, s.rw, s.a, s.b, s.rs,
                 exp_imm(op), exp_ctl(aop, op, funct3, funct7b5), ret, 1'b0};
        end
        a = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl, instret, illegal};
        check("cycle", 32'(a), 32'(e));
        last_rw = RegWrite; last_ret = instret; last_pcw = PCWrite; last_fetch = fetch;
        last_strobe = mem_req | MemWrite | IRWrite | PCWrite | RegWrite | instret;
        last_ill = illegal;
        if (trapped) ;
        else if (fetch) begin
            if (mem_ready) plan(op);
        end else if (ready) begin
            void'(script.pop_front());
            if (s.trap_next || (s.br && !legal)) trapped = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                             logic r31, int fw, int mw, int abort_at, output int ncyc);
        bit started = 1'b0;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; ALUR31 = r31;
        fw_left = fw; mw_left = mw;
        n_rw = 0; n_ret = 0; n_pcw_x = 0; ret_cyc = 0; ncyc = 0;
        forever begin
            cycle();
            ncyc++;
            if (last_rw) n_rw++;
            if (last_ret) begin n_ret++; ret_cyc = ncyc; end
            if (last_pcw && !last_fetch) n_pcw_x++;
            if (script.size() != 0) started = 1'b1;
            if (trapped || (started && script.size() == 0)) break;
            if (abort_at != 0 && ncyc == abort_at) break;
            if (ncyc >= 200) begin
                check("instr_timeout", 32'(ncyc), 32'd0);
                break;
            end
        end
    endtask

    // Asynchronous reset between clock edges; FETCH must appear at once.
    task automatic do_reset();
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("reset_outputs", {25'b0, mem_req, IRWrite, PCWrite, RegWrite, MemWrite,
                                instret, illegal}, 32'b1000000);
        script.delete();
        trapped = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, strobes, ills, pick, abort_at;
        logic [6:0] o;
        rand_ready = 1'b0; trapped = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; ALUR31 = 1'b0;
        mem_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("reset_outputs", {25'b0, mem_req, IRWrite, PCWrite, RegWrite, MemWrite,
                                instret, illegal}, 32'b1000000);
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("add_cycles", 32'(n), 32'd4);
        check("add_regwrites", 32'(n_rw), 32'd1);
        check("add_instret_cycle", 32'(ret_cyc), 32'd4);

        run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 3, 2, 0, n);
        check("lw_wait_cycles", 32'(n), 32'd10);
        check("lw_regwrites", 32'(n_rw), 32'd1);
        check("lw_instret_cycle", 32'(ret_cyc), 32'd10);

        run_instr(OP_BR, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("bne_taken_cycles", 32'(n), 32'd3);
        check("bne_taken_pcwrite", 32'(n_pcw_x), 32'd1);
        check("bne_taken_regwrite", 32'(n_rw), 32'd0);
        run_instr(OP_BR, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0, 0, n);
        check("bne_not_taken_cycles", 32'(n), 32'd3);
        check("bne_not_taken_pcwrite", 32'(n_pcw_x), 32'd0);
        check("bne_not_taken_regwrite", 32'(n_rw), 32'd0);

        run_instr(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("jalr_cycles", 32'(n), 32'd4);
        check("jalr_regwrites", 32'(n_rw), 32'd1);
        run_instr(OP_ST, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("sw_cycles", 32'(n), 32'd4);
        check("sw_instret", 32'(n_ret), 32'd1);
        run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("jal_cycles", 32'(n), 32'd4);
        run_instr(OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("lui_cycles", 32'(n), 32'd4);

        // reset while MEMREAD still waits on ready
        run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 5, 4, n);
        check("abort_no_regwrite", 32'(n_rw + n_ret), 32'd0);
        do_reset();
        run_instr(OP_R, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, n);
        check("after_reset_add_cycles", 32'(n), 32'd4);

        run_instr(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("trap_cycles", 32'(n), 32'd2);
        strobes = 0; ills = 0;
        repeat (20) begin
            cycle();
            strobes += int'(last_strobe);
            ills += int'(last_ill);
        end
        check("trap_strobes", 32'(strobes), 32'd0);
        check("trap_illegal_held", 32'(ills), 32'd20);
        do_reset();

        run_instr(OP_BR, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0, 0, n);
        check("bad_branch_cycles", 32'(n), 32'd3);
        check("bad_branch_instret", 32'(n_ret), 32'd0);
        do_reset();

        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0: o = OP_LD;   1: o = OP_ST;  2: o = OP_R;    3: o = OP_I;
                4: o = OP_BR;   5: o = OP_JAL; 6: o = OP_JALR; 7: o = OP_LUI;
                8: o = 7'($urandom_range(0, 127));
                default: o = OP_R;
            endcase
            abort_at = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 6) : 0;
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      0, 0, abort_at, n);
            if (trapped) begin
                repeat ($urandom_range(1, 5)) cycle();
                do_reset();
            end else if (abort_at != 0) begin
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
